// File: rtl/psk_mod_pkg.sv
// Types and build defaults shared by the PSK modulator and demodulator.
package psk_mod_pkg;

    typedef enum logic {MODE_BPSK = 1'b0, MODE_QPSK = 1'b1} psk_mode_t;
    typedef logic [1:0] psk_sym_t;

    // One symbol slot as it travels down the sample pipeline.
    typedef struct packed {
        logic      act;
        psk_sym_t  sym;
        psk_mode_t mode;
    } psk_slot_t;

    localparam int PSK_DATA_W_DEF    = 16;
    localparam int PSK_LUT_DEPTH_DEF = 64;
    localparam int PSK_PPS_DEF       = 4;

endpackage

// File: rtl/psk_sym_fifo.sv
// 2-entry synchronous symbol FIFO; a pop in the same cycle frees a slot for a push when full.
module psk_sym_fifo
    import psk_mod_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  psk_sym_t data_i,
    input  logic     pop_i,
    output psk_sym_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    psk_sym_t   mem_q [2];
    logic [1:0] cnt_q;
    logic       wr_q, rd_q;
    logic       do_push, do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= ~wr_q;
            if (do_pop)  rd_q <= ~rd_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/psk_modulator_mc.sv
// Runtime BPSK/QPSK modulator driving two external cosine LUT read ports.
// Optional PSK_MOD_UNDERFLOW_CNT_EN adds a saturating count of boundaries that found no symbol.
module psk_modulator_mc
    import psk_mod_pkg::*;
#(
    parameter int DATA_W             = PSK_DATA_W_DEF,
    parameter int LUT_DEPTH          = PSK_LUT_DEPTH_DEF,
    parameter int PERIODS_PER_SYMBOL = PSK_PPS_DEF,
    localparam int IDX_W             = $clog2(LUT_DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     sym_valid,
    output logic                     sym_ready,
    input  logic [1:0]               sym_data,
    output logic [IDX_W-1:0]         lut_idx_i,
    output logic [IDX_W-1:0]         lut_idx_q,
    input  logic signed [DATA_W-1:0] lut_i,
    input  logic signed [DATA_W-1:0] lut_q,
    output logic signed [DATA_W-1:0] out_i,
    output logic signed [DATA_W-1:0] out_q,
`ifdef PSK_MOD_UNDERFLOW_CNT_EN
    output logic [15:0]              underflow_cnt,
`endif
    output logic                     out_valid
);

    localparam int PER_W = (PERIODS_PER_SYMBOL > 1) ? $clog2(PERIODS_PER_SYMBOL) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LUT_DEPTH - 1);
    localparam logic [IDX_W-1:0] Q_OFS    = IDX_W'(LUT_DEPTH * 3 / 4);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SYMBOL - 1);
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX = ~S_MIN;

    logic [IDX_W-1:0]         idx_q;
    logic [PER_W-1:0]         per_q;
    psk_slot_t                slot0_q, slot1_q;
    logic signed [DATA_W-1:0] hold_i_q, hold_q_q;
    logic                     lut_live_q;
    logic signed [DATA_W-1:0] out_i_q, out_q_q;
    logic                     out_valid_q;

    logic                     boundary, push, fifo_full, fifo_empty;
    psk_sym_t                 fifo_data;
    logic signed [DATA_W-1:0] lut_i_eff, lut_q_eff, out_i_d, out_q_d;

    function automatic logic signed [DATA_W-1:0] apply_sign(
        input logic signed [DATA_W-1:0] v,
        input logic                     neg
    );
        if (!neg)       return v;
        if (v == S_MIN) return S_MAX;
        return -v;
    endfunction

    assign boundary  = en && (idx_q == IDX_LAST) && (per_q == PER_LAST);
    assign sym_ready = !fifo_full;
    assign push      = sym_valid && sym_ready && en;

    psk_sym_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (sym_data),
        .pop_i   (boundary),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The external LUT keeps reading while en is low; keep the sample that
    // belongs to stage 1 so resuming does not skip one.
    assign lut_i_eff = lut_live_q ? lut_i : hold_i_q;
    assign lut_q_eff = lut_live_q ? lut_q : hold_q_q;

    always_comb begin
        out_i_d = '0;
        out_q_d = '0;
        if (slot1_q.act) begin
            out_i_d = apply_sign(lut_i_eff, slot1_q.sym[0]);
            if (slot1_q.mode == MODE_QPSK) out_q_d = apply_sign(lut_q_eff, slot1_q.sym[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            per_q       <= '0;
            slot0_q     <= '{act: 1'b0, sym: 2'b00, mode: MODE_BPSK};
            slot1_q     <= '{act: 1'b0, sym: 2'b00, mode: MODE_BPSK};
            hold_i_q    <= '0;
            hold_q_q    <= '0;
            lut_live_q  <= 1'b1;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) per_q <= (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
            if (boundary) begin
                slot0_q.act  <= !fifo_empty;
                slot0_q.sym  <= fifo_empty ? 2'b00 : fifo_data;
                slot0_q.mode <= psk_mode_t'(mode);
            end
            slot1_q     <= slot0_q;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= slot1_q.act;
            lut_live_q  <= 1'b1;
        end else if (lut_live_q) begin
            hold_i_q   <= lut_i;
            hold_q_q   <= lut_q;
            lut_live_q <= 1'b0;
        end
    end

`ifdef PSK_MOD_UNDERFLOW_CNT_EN
    logic [15:0] underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                                          underflow_q <= 16'h0000;
        else if (boundary && fifo_empty && underflow_q != 16'hFFFF) underflow_q <= underflow_q + 16'h0001;
    end

    assign underflow_cnt = underflow_q;
`endif

    assign lut_idx_i = idx_q;
    assign lut_idx_q = idx_q + Q_OFS;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

endmodule
